scrod_trg_responder: RTL and testbench

- SCROD-side far end of the cajipci TRG/ACK trigger link: one instance per SCROD, receiving one TRG line and driving the matching ACK line back to the cajipci trigger block.
- Synchronises and glitch-filters TRG, then either accepts or rejects the trigger. On accept it pulses a local digitizer trigger, numbers the event, and holds ACK high as a busy/flow-control indication until readout completes and TRG is released.

---
 rtl/scrod_trg_pkg.sv | 13 +
 rtl/scrod_trg_responder_sync_filter.sv | 48 ++++
 rtl/scrod_trg_responder.sv | 140 ++++++++++++++
 tb/tb_scrod_trg_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scrod_trg_pkg.sv
// Shared types and constants for the SCROD-side TRG/ACK trigger responder.
package scrod_trg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACKED    = 2'd1,
        WAIT_LOW = 2'd2
    } trg_state_e;

    localparam int CNT_W_DEF    = 16;
    localparam int FILTER_CNT_W = 4;

endpackage

// File: rtl/scrod_trg_responder_sync_filter.sv
// Two-flop synchroniser for the asynchronous TRG line plus a run-length glitch filter.
module trg_sync_filter
    import scrod_trg_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic trg_i,
    output logic trg_s_o,
    output logic qualified_o
);

    localparam logic [FILTER_CNT_W-1:0] LEN    = FILTER_CNT_W'(FILTER_LEN);
    localparam logic [FILTER_CNT_W-1:0] LEN_M1 = FILTER_CNT_W'(FILTER_LEN - 1);

    logic                    sync1_q;
    logic                    sync2_q;
    logic [FILTER_CNT_W-1:0] cnt_q;
    logic [FILTER_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != LEN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= trg_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    // Qualifies in the cycle the counter is about to reach FILTER_LEN, so the
    // accept edge lands 2+FILTER_LEN edges after TRG is first sampled high.
    assign trg_s_o     = sync2_q;
    assign qualified_o = sync2_q && (cnt_q >= LEN_M1);

endmodule

// File: rtl/scrod_trg_responder.sv
// SCROD far end of the TRG/ACK trigger link: accepts or rejects triggers and holds ACK as busy.
// Optional watchdog on the ACKED state is compiled in with `define SCROD_TRG_TIMEOUT_EN.
module scrod_trg_responder
    import scrod_trg_pkg::*;
#(
    parameter int FILTER_LEN  = 3,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             CLK_42MHZ,
    input  logic             RESET_N,
    input  logic             TRG,
    output logic             ACK,
    input  logic             ENABLE,
    input  logic             READY,
    input  logic             READOUT_DONE,
    input  logic             CLR_CNT,
    output logic             TRG_LOCAL,
    output logic [CNT_W-1:0] EVT_NUM,
    output logic [CNT_W-1:0] MISSED_CNT,
    output logic             BUSY,
    output logic             TIMEOUT_ERR
);

    trg_state_e       state_q, state_d;
    logic             ack_q, trg_local_q, trg_local_d;
    logic [CNT_W-1:0] evt_q, evt_d, missed_q, missed_d;
    logic             low_seen_q, low_seen_d, done_seen_q, done_seen_d;
    logic             low_now, done_now;
    logic             trg_s, qualified;
    logic             timeout_hit;

    trg_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
        .clk_i       (CLK_42MHZ),
        .rst_n_i     (RESET_N),
        .trg_i       (TRG),
        .trg_s_o     (trg_s),
        .qualified_o (qualified)
    );

`ifdef SCROD_TRG_TIMEOUT_EN
    localparam int             WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    assign timeout_hit = (state_q == ACKED) && (wdog_q == WD_LIMIT) && !done_seen_q;

    always_ff @(posedge CLK_42MHZ) begin
        if (!RESET_N) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q != ACKED) begin
                wdog_q <= '0;
            end else if (wdog_q != WD_LIMIT) begin
                wdog_q <= wdog_q + 1'b1;
            end
            err_q <= (err_q | timeout_hit) & ~CLR_CNT;
        end
    end

    assign TIMEOUT_ERR = err_q;
`else
    assign timeout_hit = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    // DONE is not sampled during the TRG_LOCAL cycle; it must belong to this event.
    assign low_now  = low_seen_q | ~trg_s;
    assign done_now = done_seen_q | (READOUT_DONE & ~trg_local_q) | timeout_hit;

    always_comb begin
        state_d     = state_q;
        trg_local_d = 1'b0;
        evt_d       = evt_q;
        missed_d    = missed_q;
        low_seen_d  = low_seen_q;
        done_seen_d = done_seen_q;
        case (state_q)
            IDLE: begin
                low_seen_d  = 1'b0;
                done_seen_d = 1'b0;
                if (qualified) begin
                    if (!ENABLE) begin
                        state_d = WAIT_LOW;
                    end else if (!READY) begin
                        if (missed_q != '1) missed_d = missed_q + 1'b1;
                        state_d = WAIT_LOW;
                    end else begin
                        trg_local_d = 1'b1;
                        evt_d       = evt_q + 1'b1;
                        state_d     = ACKED;
                    end
                end
            end
            ACKED: begin
                low_seen_d  = low_now;
                done_seen_d = done_now;
                if (low_now && done_now) state_d = IDLE;
            end
            WAIT_LOW: begin
                if (!trg_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (CLR_CNT) begin
            evt_d    = '0;
            missed_d = '0;
        end
    end

    always_ff @(posedge CLK_42MHZ) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            trg_local_q <= 1'b0;
            evt_q       <= '0;
            missed_q    <= '0;
            low_seen_q  <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= (state_d == ACKED);
            trg_local_q <= trg_local_d;
            evt_q       <= evt_d;
            missed_q    <= missed_d;
            low_seen_q  <= low_seen_d;
            done_seen_q <= done_seen_d;
        end
    end

    assign ACK        = ack_q;
    assign TRG_LOCAL  = trg_local_q;
    assign EVT_NUM    = evt_q;
    assign MISSED_CNT = missed_q;
    assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_scrod_trg_responder.sv
// Directed bench for scrod_trg_responder; counters narrowed to 8 bits so wrap/saturation are reachable.
module tb_scrod_trg_responder;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, trg, enable, ready, done, clr;
    logic          ack, trg_local, busy, timeout_err;
    logic [CW-1:0] evt_num, missed;

    int n_vec = 0;
    int n_err = 0;

    scrod_trg_responder #(
        .FILTER_LEN  (3),
        .CNT_W       (CW)
`ifdef SCROD_TRG_TIMEOUT_EN
        , .TIMEOUT_CYC (100)
`endif
    ) dut (
        .CLK_42MHZ    (clk),
        .RESET_N      (rst_n),
        .TRG          (trg),
        .ACK          (ack),
        .ENABLE       (enable),
        .READY        (ready),
        .READOUT_DONE (done),
        .CLR_CNT      (clr),
        .TRG_LOCAL    (trg_local),
        .EVT_NUM      (evt_num),
        .MISSED_CNT   (missed),
        .BUSY         (busy),
        .TIMEOUT_ERR  (timeout_err)
    );

    always #12 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL global_time_limit reached, required bench to finish");
        $fatal(1);
    end

    // Advance past one rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle busy=%b after %0d cycles, required 0", busy, k);
        end
    endtask

    // TRG high for exactly FILTER_LEN samples, then readout completes after TRG_LOCAL.
    task automatic fast_accept();
        trg = 1'b1;
        repeat (3) tick();
        trg = 1'b0;
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_idle(8);
    endtask

    task automatic fast_reject();
        trg = 1'b1;
        repeat (3) tick();
        trg = 1'b0;
        repeat (4) tick();
        wait_idle(8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trg = 1'b0; enable = 1'b1; ready = 1'b1; done = 1'b0; clr = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({ack, trg_local, busy, timeout_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags ack/tl/busy/terr=%b required 0000", {ack, trg_local, busy, timeout_err});
        end
        n_vec++;
        if (evt_num !== 8'd0 || missed !== 8'd0) begin
            n_err++;
            $display("FAIL reset_counters evt=%0d missed=%0d required 0/0", evt_num, missed);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_glitch();
        trg = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 2) trg = 1'b0;
            n_vec++;
            if (ack !== 1'b0 || trg_local !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL glitch e=%0d ack/tl/busy=%b%b%b required 000", e, ack, trg_local, busy);
            end
        end
        n_vec++;
        if (evt_num !== 8'd0 || missed !== 8'd0) begin
            n_err++;
            $display("FAIL glitch_counters evt=%0d missed=%0d required 0/0", evt_num, missed);
        end
    endtask

    task automatic test_clean_accept();
        logic exp_ack, exp_tl;
        trg = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            tick();
            exp_ack = (e >= 5 && e <= 30);
            exp_tl  = (e == 5);
            n_vec++;
            if (ack !== exp_ack || trg_local !== exp_tl) begin
                n_err++;
                $display("FAIL clean_accept e=%0d ack=%b tl=%b required ack=%b tl=%b", e, ack, trg_local, exp_ack, exp_tl);
            end
            if (e == 20) trg = 1'b0;
            if (e == 30) done = 1'b1;
            if (e == 31) done = 1'b0;
        end
        n_vec++;
        if (evt_num !== 8'd1 || missed !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL clean_accept_end evt=%0d missed=%0d busy=%b required 1/0/0", evt_num, missed, busy);
        end
    endtask

    task automatic test_busy_reject();
        ready = 1'b0;
        for (int p = 1; p <= 2; p++) begin
            trg = 1'b1;
            for (int e = 1; e <= 10; e++) begin
                tick();
                n_vec++;
                if (ack !== 1'b0 || trg_local !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_reject p=%0d e=%0d ack=%b tl=%b required 0/0", p, e, ack, trg_local);
                end
                if (e == 5) begin
                    n_vec++;
                    if (missed !== 8'(p) || busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL busy_reject_cnt p=%0d missed=%0d busy=%b required %0d/1", p, missed, busy, p);
                    end
                end
            end
            trg = 1'b0;
            repeat (2) tick();
            wait_idle(6);
        end
        n_vec++;
        if (missed !== 8'd2 || evt_num !== 8'd1) begin
            n_err++;
            $display("FAIL busy_reject_end missed=%0d evt=%0d required 2/1", missed, evt_num);
        end
        ready = 1'b1;
    endtask

    task automatic test_disabled();
        enable = 1'b0;
        trg = 1'b1;
        repeat (3) tick();
        trg = 1'b0;
        repeat (2) tick();
        n_vec++;
        if (busy !== 1'b1 || ack !== 1'b0 || trg_local !== 1'b0) begin
            n_err++;
            $display("FAIL disabled busy/ack/tl=%b%b%b required 100", busy, ack, trg_local);
        end
        repeat (2) tick();
        wait_idle(6);
        n_vec++;
        if (evt_num !== 8'd1 || missed !== 8'd2) begin
            n_err++;
            $display("FAIL disabled_counters evt=%0d missed=%0d required 1/2", evt_num, missed);
        end
        enable = 1'b1;
    endtask

    // DONE during the TRG_LOCAL cycle must not complete the event; ENABLE dropping must not abort it.
    task automatic test_done_ignored();
        logic exp_ack;
        trg = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp_ack = (e >= 5 && e <= 12);
            n_vec++;
            if (ack !== exp_ack) begin
                n_err++;
                $display("FAIL done_ignored e=%0d ack=%b required %b", e, ack, exp_ack);
            end
            if (e == 3)  trg = 1'b0;
            if (e == 5)  done = 1'b1;
            if (e == 6)  done = 1'b0;
            if (e == 8)  enable = 1'b0;
            if (e == 12) done = 1'b1;
            if (e == 13) begin done = 1'b0; enable = 1'b1; end
        end
        n_vec++;
        if (evt_num !== 8'd2) begin
            n_err++;
            $display("FAIL done_ignored_evt evt=%0d required 2", evt_num);
        end
    endtask

    task automatic test_done_first();
        logic exp_ack;
        trg = 1'b1;
        for (int e = 1; e <= 46; e++) begin
            tick();
            exp_ack = (e >= 5 && e <= 42);
            n_vec++;
            if (ack !== exp_ack) begin
                n_err++;
                $display("FAIL done_first e=%0d ack=%b required %b", e, ack, exp_ack);
            end
            if (e == 12) done = 1'b1;
            if (e == 13) done = 1'b0;
            if (e == 40) trg = 1'b0;
        end
    endtask

    // TRG falls first, re-rises inside ACKED with READY low, then DONE completes the event.
    task automatic test_low_first();
        logic exp_ack;
        trg = 1'b1;
        for (int e = 1; e <= 44; e++) begin
            tick();
            exp_ack = (e >= 5 && e <= 40);
            n_vec++;
            if (ack !== exp_ack) begin
                n_err++;
                $display("FAIL low_first e=%0d ack=%b required %b", e, ack, exp_ack);
            end
            if (e == 10) trg = 1'b0;
            if (e == 15) ready = 1'b0;
            if (e == 20) trg = 1'b1;
            if (e == 26) trg = 1'b0;
            if (e == 30) ready = 1'b1;
            if (e == 40) done = 1'b1;
            if (e == 41) done = 1'b0;
        end
        n_vec++;
        if (evt_num !== 8'd4 || missed !== 8'd2 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL low_first_end evt=%0d missed=%0d busy=%b required 4/2/0", evt_num, missed, busy);
        end
    endtask

    task automatic test_clr_coincide();
        trg = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) begin
                n_vec++;
                if (evt_num !== 8'd0 || missed !== 8'd0 || ack !== 1'b1 || trg_local !== 1'b1) begin
                    n_err++;
                    $display("FAIL clr_coincide evt=%0d missed=%0d ack=%b tl=%b required 0/0/1/1",
                             evt_num, missed, ack, trg_local);
                end
            end
            if (e == 3) trg = 1'b0;
            if (e == 4) clr = 1'b1;
            if (e == 5) clr = 1'b0;
            if (e == 6) done = 1'b1;
            if (e == 7) done = 1'b0;
        end
        wait_idle(6);
    endtask

    task automatic test_counters();
        for (int i = 0; i < 255; i++) fast_accept();
        n_vec++;
        if (evt_num !== 8'd255) begin
            n_err++;
            $display("FAIL evt_preload evt=%0d required 255", evt_num);
        end
        fast_accept();
        n_vec++;
        if (evt_num !== 8'd0) begin
            n_err++;
            $display("FAIL evt_wrap evt=%0d required 0", evt_num);
        end
        ready = 1'b0;
        for (int i = 0; i < 255; i++) fast_reject();
        n_vec++;
        if (missed !== 8'd255) begin
            n_err++;
            $display("FAIL missed_preload missed=%0d required 255", missed);
        end
        fast_reject();
        n_vec++;
        if (missed !== 8'd255 || evt_num !== 8'd0) begin
            n_err++;
            $display("FAIL missed_saturate missed=%0d evt=%0d required 255/0", missed, evt_num);
        end
        ready = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++;
        if (missed !== 8'd0 || evt_num !== 8'd0) begin
            n_err++;
            $display("FAIL clr_counters missed=%0d evt=%0d required 0/0", missed, evt_num);
        end
    endtask

    task automatic test_reset_mid();
        trg = 1'b1;
        repeat (3) tick();
        trg = 1'b0;
        repeat (2) tick();
        n_vec++;
        if (ack !== 1'b1 || evt_num !== 8'd1) begin
            n_err++;
            $display("FAIL reset_mid_pre ack=%b evt=%0d required 1/1", ack, evt_num);
        end
        rst_n = 1'b0;
        tick();
        n_vec++;
        if ({ack, trg_local, busy} !== 3'b000 || evt_num !== 8'd0 || missed !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid ack/tl/busy=%b evt=%0d missed=%0d required 000/0/0",
                     {ack, trg_local, busy}, evt_num, missed);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        n_vec++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_post busy=%b ack=%b required 0/0", busy, ack);
        end
    endtask

`ifdef SCROD_TRG_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_ack, exp_err;
        trg = 1'b1;
        for (int e = 1; e <= 126; e++) begin
            tick();
            exp_ack = (e >= 5 && e <= 122);
            exp_err = (e >= 106);
            n_vec++;
            if (ack !== exp_ack || timeout_err !== exp_err) begin
                n_err++;
                $display("FAIL timeout e=%0d ack=%b terr=%b required %b/%b", e, ack, timeout_err, exp_ack, exp_err);
            end
            if (e == 120) trg = 1'b0;
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clr terr=%b required 0", timeout_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_clean_accept();
        test_busy_reject();
        test_disabled();
        test_done_ignored();
        test_done_first();
        test_low_first();
        test_clr_coincide();
        test_counters();
        test_reset_mid();
`ifdef SCROD_TRG_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
